// File: rtl/ucsbece154a_dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, default geometry, counter width.
package ucsbece154a_dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    RESP = ST_RESP
  } dmem_state_e;

  localparam int unsigned DMEM_DEPTH_DEFAULT   = 64;
  localparam int unsigned DMEM_LATENCY_DEFAULT = 1;
  localparam int unsigned DMEM_CNT_W           = 4;

endpackage

// File: rtl/ucsbece154a_dmem_array.sv
// Word array with synchronous write and registered read; RAM stays probeable by benches.
import ucsbece154a_dmem_pkg::*;

module ucsbece154a_dmem_array #(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] RAM [0:DEPTH-1];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      RAM[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'h0;
    end else if (clr) begin
      rdata <= 32'h0;
    end else if (re) begin
      rdata <= RAM[idx];
    end
  end

endmodule

// File: rtl/ucsbece154a_dmem_resp.sv
// Latency-configurable data-memory responder with valid/ready request and response channels.
// Optional misaligned-access error reporting: UCSBECE154A_DMEM_MISALIGN_ERR_EN.
import ucsbece154a_dmem_pkg::*;

module ucsbece154a_dmem_resp #(
  parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q;
  logic [IDX_W-1:0]      idx_q;
  logic [31:0]           wdata_q;
  logic                  accept, commit, misalign;
  logic                  unused_addr;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_ready && req_valid && !reset;
  assign commit    = (state_q == BUSY) && (cnt_q == '0) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = DMEM_CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_addr[IDX_W+1:2];
      wdata_q <= req_wdata;
    end
  end

`ifdef UCSBECE154A_DMEM_MISALIGN_ERR_EN
  logic [1:0] lo_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q <= req_addr[1:0];
    end
  end

  assign misalign = (lo_q != 2'b00);

  // Error flag lives only for the duration of the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= misalign;
    end else if (rsp_valid && rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err     = err_q;
  assign unused_addr = ^req_addr[31:IDX_W+2];
`else
  assign misalign    = 1'b0;
  assign rsp_err     = 1'b0;
  assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

  // Misaligned accesses touch nothing and return zero, like a store.
  ucsbece154a_dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit && we_q && !misalign),
    .re    (commit && !we_q && !misalign),
    .clr   (commit && (we_q || misalign)),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_ucsbece154a_dmem_resp.sv
// Directed bench for ucsbece154a_dmem_resp: three instances at LATENCY 1, 3 and 4.
module tb_ucsbece154a_dmem_resp;

`ifdef UCSBECE154A_DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic [2:0]  reset;
  logic [2:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    ucsbece154a_dmem_resp #(
      .DEPTH   (64),
      .LATENCY ((k == 0) ? 1 : ((k == 1) ? 3 : 4))
    ) dmem (
      .clk       (clk),
      .reset     (reset[k]),
      .req_valid (req_valid[k]),
      .req_ready (req_ready[k]),
      .req_we    (req_we[k]),
      .req_addr  (req_addr[k]),
      .req_wdata (req_wdata[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k]),
      .rsp_rdata (rsp_rdata[k]),
      .rsp_err   (rsp_err[k])
    );
  end

  function automatic logic [31:0] peek(input int k, input int i);
    case (k)
      0:       peek = g_dut[0].dmem.u_array.RAM[i];
      1:       peek = g_dut[1].dmem.u_array.RAM[i];
      default: peek = g_dut[2].dmem.u_array.RAM[i];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          hold;
    int          ridx;
    logic [31:0] exp_ram;
  } vec_t;

  vec_t vecs [10];

  // One full transaction: accept, wait for the response, optional backpressure, handshake.
  task automatic txn(input string tag, input int k, input int lat, input vec_t v);
    int n;
    check({tag, " req_ready before"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = v.we;
    req_addr[k]  = v.addr;
    req_wdata[k] = v.wdata;
    tick();
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " rdata"}, rsp_rdata[k], v.exp_rd);
    check({tag, " err"}, 32'(rsp_err[k]), 32'(v.exp_err));
    check({tag, " ram"}, peek(k, v.ridx), v.exp_ram);
    check({tag, " req_ready busy"}, 32'(req_ready[k]), 32'd0);
    if (v.hold > 0) begin
      // A request offered during RESP must be ignored.
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h60;
      req_wdata[k] = 32'hDEAD;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        check({tag, " hold valid"}, 32'(rsp_valid[k]), 32'd1);
        check({tag, " hold rdata"}, rsp_rdata[k], v.exp_rd);
        check({tag, " hold req_ready"}, 32'(req_ready[k]), 32'd0);
      end
      req_valid[k] = 1'b0;
    end
    rsp_ready[k] = 1'b1;
    tick();
    rsp_ready[k] = 1'b0;
    check({tag, " valid after hs"}, 32'(rsp_valid[k]), 32'd0);
    check({tag, " ready after hs"}, 32'(req_ready[k]), 32'd1);
    check({tag, " err after hs"}, 32'(rsp_err[k]), 32'd0);
    check({tag, " ram after hs"}, peek(k, v.ridx), v.exp_ram);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    vec_t v;

    vecs[0] = '{1'b1, 32'h60,       32'h7,        32'h0,        1'b0,   0, 24, 32'h7};
    vecs[1] = '{1'b0, 32'h60,       32'h0,        32'h7,        1'b0,   5, 24, 32'h7};
    vecs[2] = '{1'b1, 32'h100,      32'h5,        32'h0,        1'b0,   0, 0,  32'h5};
    vecs[3] = '{1'b0, 32'h0,        32'h0,        32'h5,        1'b0,   0, 0,  32'h5};
    vecs[4] = '{1'b0, 32'h100,      32'h0,        32'h5,        1'b0,   1, 0,  32'h5};
    vecs[5] = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 32'h0,        1'b0,   0, 63, 32'h12345678};
    vecs[6] = '{1'b0, 32'hFC,       32'h0,        32'h12345678, 1'b0,   2, 63, 32'h12345678};
    vecs[7] = '{1'b1, 32'h62,       32'h1,        32'h0,        ERR_EN, 0, 24,
                (ERR_EN ? 32'h7 : 32'h1)};
    vecs[8] = '{1'b0, 32'h60,       32'h0,        (ERR_EN ? 32'h7 : 32'h1), 1'b0, 0, 24,
                (ERR_EN ? 32'h7 : 32'h1)};
    vecs[9] = '{1'b0, 32'h63,       32'h0,        (ERR_EN ? 32'h0 : 32'h1), ERR_EN, 0, 24,
                (ERR_EN ? 32'h7 : 32'h1)};

    reset     = 3'b111;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("reset req_ready", 32'(req_ready[k]), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("reset rsp_rdata", rsp_rdata[k], 32'd0);
      check("reset rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    reset = 3'b000;
    tick();

    // Table vectors on the LATENCY=3 instance.
    for (int i = 0; i < 10; i++) begin
      txn($sformatf("vec%0d", i), 1, 3, vecs[i]);
    end

    // Back-to-back stores, LATENCY=1, rsp_ready held high.
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h64;
    req_wdata[0] = 32'h19;
    tick();
    req_addr[0]  = 32'h68;
    req_wdata[0] = 32'hBEEF000;
    check("b2b first busy", 32'(req_ready[0]), 32'd0);
    tick();
    check("b2b first rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("b2b first ram", peek(0, 25), 32'h19);
    n = 1;
    while (!req_ready[0] && n < 10) begin
      tick();
      n++;
    end
    // BUSY for LATENCY cycles plus one RESP cycle before IDLE again.
    check("b2b ready gap", 32'(n), 32'd2);
    tick();
    req_valid[0] = 1'b0;
    check("b2b second accepted", 32'(req_ready[0]), 32'd0);
    tick();
    check("b2b second rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("b2b second rdata", rsp_rdata[0], 32'd0);
    tick();
    rsp_ready[0] = 1'b0;
    check("b2b idle", 32'(req_ready[0]), 32'd1);
    check("b2b ram25", peek(0, 25), 32'h19);
    check("b2b ram26", peek(0, 26), 32'hBEEF000);

    // Reset while BUSY discards the pending store (LATENCY=4).
    v = '{1'b1, 32'h10, 32'h33, 32'h0, 1'b0, 0, 4, 32'h33};
    txn("rst seed", 2, 4, v);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h10;
    req_wdata[2] = 32'hAA;
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    reset[2] = 1'b1;
    tick();
    reset[2] = 1'b0;
    check("rst busy rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("rst busy req_ready", 32'(req_ready[2]), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("rst busy no late rsp", 32'(rsp_valid[2]), 32'd0);
    check("rst busy ram4", peek(2, 4), 32'h33);

    // Reset while in RESP drops the response.
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h10;
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst resp pre valid", 32'(rsp_valid[2]), 32'd1);
    check("rst resp pre rdata", rsp_rdata[2], 32'h33);
    reset[2] = 1'b1;
    tick();
    check("rst resp valid", 32'(rsp_valid[2]), 32'd0);
    check("rst resp rdata", rsp_rdata[2], 32'd0);
    check("rst resp req_ready", 32'(req_ready[2]), 32'd1);

    // Reset and req_valid together: nothing accepted.
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h10;
    req_wdata[2] = 32'h55;
    tick();
    reset[2]     = 1'b0;
    req_valid[2] = 1'b0;
    check("rst+req req_ready", 32'(req_ready[2]), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("rst+req no rsp", 32'(rsp_valid[2]), 32'd0);
    check("rst+req ram4", peek(2, 4), 32'h33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
